// File: rtl/slip_tx_encoder.sv
// SLIP frame encoder: END, escaped payload (MSB byte first), optional CRC-8, END.
// Define SLIP_TX_CRC_EN to append an escaped CRC-8 (poly 0x07) before the closing END.
module slip_tx_encoder #(
    parameter int MSG_BYTES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*MSG_BYTES-1:0] msg,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int W  = 8 * MSG_BYTES;
    localparam int IW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(MSG_BYTES - 1);

    localparam logic [7:0] END     = 8'hC0;
    localparam logic [7:0] ESC     = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        DATA,
        ESC2,
`ifdef SLIP_TX_CRC_EN
        CRC,
`endif
        EOF
    } state_t;

`ifdef SLIP_TX_CRC_EN
    localparam state_t TAIL = CRC;
`else
    localparam state_t TAIL = EOF;
`endif

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    msg_q, msg_d;
    logic [7:0]      out_byte_q, out_byte_d;
    logic            out_valid_q, out_valid_d;
    logic            xfer;
    logic [7:0]      cur_b;
    logic [7:0]      nxt_b;
    logic [7:0]      esc_b;
`ifdef SLIP_TX_CRC_EN
    logic [7:0]      crc_q, crc_d;
    logic            esc_crc_q, esc_crc_d;
`endif

    function automatic logic is_special(input logic [7:0] b);
        return (b == END) || (b == ESC);
    endfunction

    function automatic logic [7:0] byte_at(input logic [W-1:0] m,
                                           input logic [IW-1:0] i);
        logic [W-1:0] sh;
        sh = m << (8 * i);
        return sh[W-1 -: 8];
    endfunction

`ifdef SLIP_TX_CRC_EN
    function automatic logic [7:0] crc8(input logic [7:0] c,
                                       input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            msg_q       <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef SLIP_TX_CRC_EN
            crc_q       <= '0;
            esc_crc_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            msg_q       <= msg_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
`ifdef SLIP_TX_CRC_EN
            crc_q       <= crc_d;
            esc_crc_q   <= esc_crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        msg_d   = msg_q;
`ifdef SLIP_TX_CRC_EN
        crc_d     = crc_q;
        esc_crc_d = esc_crc_q;
`endif
        xfer  = out_valid_q && out_ready;
        cur_b = byte_at(msg_q, idx_q);
        case (state_q)
            IDLE: if (msg_valid) begin
                state_d = SOF;
                msg_d   = msg;
                idx_d   = '0;
`ifdef SLIP_TX_CRC_EN
                crc_d     = '0;
                esc_crc_d = 1'b0;
`endif
            end
            SOF: if (xfer) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (xfer) begin
`ifdef SLIP_TX_CRC_EN
                crc_d = crc8(crc_q, cur_b);
`endif
                if (is_special(cur_b))
                    state_d = ESC2;
                else if (idx_q == LAST)
                    state_d = TAIL;
                else
                    idx_d = idx_q + 1'b1;
            end
            ESC2: if (xfer) begin
`ifdef SLIP_TX_CRC_EN
                if (esc_crc_q)
                    state_d = EOF;
                else
`endif
                if (idx_q == LAST)
                    state_d = TAIL;
                else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DATA;
                end
            end
`ifdef SLIP_TX_CRC_EN
            CRC: if (xfer) begin
                if (is_special(crc_q)) begin
                    state_d   = ESC2;
                    esc_crc_d = 1'b1;
                end else begin
                    state_d = EOF;
                end
            end
`endif
            EOF: if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next state so they stay put during stalls.
    always_comb begin
        out_valid_d = 1'b1;
        out_byte_d  = '0;
        nxt_b       = byte_at(msg_d, idx_d);
`ifdef SLIP_TX_CRC_EN
        esc_b = esc_crc_d ? crc_d : nxt_b;
`else
        esc_b = nxt_b;
`endif
        case (state_d)
            IDLE: out_valid_d = 1'b0;
            SOF:  out_byte_d  = END;
            DATA: out_byte_d  = is_special(nxt_b) ? ESC : nxt_b;
            ESC2: out_byte_d  = (esc_b == END) ? ESC_END : ESC_ESC;
`ifdef SLIP_TX_CRC_EN
            CRC:  out_byte_d  = is_special(crc_d) ? ESC : crc_d;
`endif
            EOF:  out_byte_d  = END;
            default: out_valid_d = 1'b0;
        endcase
    end

    assign msg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/slip_tx_encoder.md
SLIP_TX_ENCODER -- requirements
Module: slip_tx_encoder

Interface
REQ-001 Parameter MSG_BYTES, default 5, number of payload bytes per message; msg width is 8*MSG_BYTES.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 msg  input  8*MSG_BYTES  message to frame, sent MSB byte first.
REQ-005 msg_valid  input  1  msg holds a message to send.
REQ-006 msg_ready  output  1  encoder accepts msg this cycle.
REQ-007 out_byte  output  8  current SLIP-encoded byte.
REQ-008 out_valid  output  1  out_byte valid.
REQ-009 out_ready  input  1  downstream (byte FIFO / UART) accepts out_byte.
REQ-010 busy  output  1  frame in progress (state != IDLE).

Function
REQ-011 SLIP constants: END=0xC0, ESC=0xDB, ESC_END=0xDC, ESC_ESC=0xDD.
REQ-012 Frame: END, escaped payload bytes, [escaped CRC per REQ-030], END.
REQ-013 Accept: msg_ready=1 only in IDLE; message captured into an internal register on msg_valid&msg_ready; msg then don't-care.
REQ-014 Byte transfer occurs only on out_valid&out_ready; out_byte and out_valid are registered, held stable while out_valid&!out_ready.
REQ-015 States: IDLE, SOF, DATA, ESC2, CRC, EOF; all transitions occur on a transfer except IDLE->SOF.
REQ-016 IDLE->SOF on accept; first out_valid (0xC0) in the cycle after accept; no byte presented in the accept cycle.
REQ-017 SOF: present 0xC0; on transfer ->DATA with byte index 0.
REQ-018 DATA: payload byte b=0xC0 or 0xDB presents 0xDB then ->ESC2; otherwise presents b and increments index.
REQ-019 ESC2: presents 0xDC (b=0xC0) or 0xDD (b=0xDB); on transfer increments index, ->DATA.
REQ-020 After last payload byte (index MSG_BYTES-1) transferred: ->CRC if enabled, else ->EOF.
REQ-021 EOF: present 0xC0; on transfer ->IDLE; msg_ready=1 on the next cycle (no back-to-back overlap; shared END not used).
REQ-022 Index counter width ceil(log2(MSG_BYTES)); it does not wrap within a frame.
REQ-023 out_ready ignored when out_valid=0; msg_valid ignored when not IDLE.
REQ-024 With out_ready held 1 and no escapes: frame of MSG_BYTES+2 bytes on consecutive cycles.

Reset
REQ-025 rst=1 on a clock edge: state=IDLE, out_valid=0, out_byte=0x00, busy=0, index=0, CRC=0x00, msg_ready=1 in the first cycle after rst deasserts.
REQ-026 rst mid-frame aborts the frame immediately with no trailing END; next frame starts cleanly with END.
REQ-027 rst has priority over every simultaneous event, including accept and transfer.

Configuration
REQ-028 Macro SLIP_TX_CRC_EN selects the CRC feature.
REQ-029 Without SLIP_TX_CRC_EN: CRC state and logic absent; the frame matches REQ-012 with no CRC byte.
REQ-030 With SLIP_TX_CRC_EN: CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over the raw unescaped payload bytes; the CRC state sends the CRC byte, escaped per REQ-018/019, before EOF.

Verification
REQ-031 msg=0x0102030405, out_ready=1 -> C0 01 02 03 04 05 C0 on 7 consecutive cycles starting 1 cycle after accept; msg_ready high again 1 cycle after final C0.
REQ-032 msg=0xC0DB000000 -> C0 DB DC DB DD 00 00 00 C0.
REQ-033 Backpressure: out_ready toggled 1,0,0,1,... on msg=0x0102030405 -> same byte sequence; out_byte stable during stalls; no duplication or loss.
REQ-034 rst pulsed after 3 bytes transferred, then msg=0x1111111111 -> new frame C0 11 11 11 11 11 C0; busy=0 and out_valid=0 on the cycle after rst.
REQ-035 SLIP_TX_CRC_EN defined, msg=0x0000000001 -> C0 00 00 00 00 01 07 C0; msg=0x0000000000 -> C0 00 00 00 00 00 00 C0.
REQ-036 msg_valid held high continuously -> frames separated by one idle cycle; each message accepted exactly once.
